// File: rtl/dac_pkg.sv
// Shared definitions for both ends of the r2r-dac serial link.
// This package holds the frame line levels, the transmitter state encoding and the default width.
package dac_pkg;

  localparam int unsigned DAC_D_W   = 8;
  localparam int unsigned DAC_BIN_W = $clog2(DAC_D_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/t2b.sv
// Thermometer-to-binary compressor: saturated popcount plus a legality flag.
// This is the inverse of the receiver's b2t expander.
module t2b #(
  parameter int unsigned therm_width = 8,
  parameter int unsigned bin_width   = $clog2(therm_width)
) (
  input  logic [therm_width-1:0] therm_in,
  output logic [bin_width-1:0]   bin_out,
  output logic                   legal
);

  logic [bin_width:0] count;
  logic               seen_zero;

  always_comb begin
    count     = '0;
    legal     = 1'b1;
    seen_zero = 1'b0;
    for (int unsigned i = 0; i < therm_width; i++) begin
      count = count + {{bin_width{1'b0}}, therm_in[i]};
      if (!therm_in[i])
        seen_zero = 1'b1;
      else if (seen_zero)
        legal = 1'b0;
    end
    // All bits set is the one count that overflows the binary width.
    if (therm_in[therm_width-1])
      legal = 1'b0;
    bin_out = count[bin_width] ? '1 : count[bin_width-1:0];
  end

endmodule

// File: rtl/therm_serial_encoder.sv
// Accepts a thermometer word over valid/ready and sends its binary value as a framed bitstream.
// The frame is a start bit, BIN_W data bits MSB first, then a stop bit.
module therm_serial_encoder
  import dac_pkg::*;
#(
  parameter int unsigned D_W = DAC_D_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [D_W-1:0] therm_in,
  input  logic           valid_in,
  output logic           ready_out,
  output logic           serial_out,
  output logic           busy,
  output logic           frame_done,
  output logic           code_err
);

  localparam int unsigned BIN_W = $clog2(D_W);

  tx_state_t        state, state_next;
  logic [BIN_W-1:0] shift, shift_next;
  logic [BIN_W-1:0] bit_cnt, bit_cnt_next;
  logic             serial_next;
  logic [BIN_W-1:0] bin_val;
  logic             legal;
  logic             load;

  t2b #(
    .therm_width(D_W),
    .bin_width  (BIN_W)
  ) u_t2b (
    .therm_in(therm_in),
    .bin_out (bin_val),
    .legal   (legal)
  );

  assign ready_out  = (state == IDLE) || (state == STOP);
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP);
  assign load       = valid_in && ready_out;

  // serial_next is the line level for the state being entered, so the registered
  // serial_out lines up with state without a combinational output path.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    serial_next  = IDLE_LVL;
    case (state)
      IDLE, STOP: begin
        if (load) begin
          state_next  = START;
          shift_next  = bin_val;
          serial_next = START_BIT;
        end else begin
          state_next  = IDLE;
        end
      end
      START: begin
        state_next   = DATA;
        bit_cnt_next = BIN_W'(BIN_W - 1);
        serial_next  = shift[BIN_W-1];
        shift_next   = shift << 1;
      end
      DATA: begin
        if (bit_cnt == '0) begin
          state_next  = STOP;
          serial_next = STOP_BIT;
        end else begin
          bit_cnt_next = bit_cnt - BIN_W'(1);
          serial_next  = shift[BIN_W-1];
          shift_next   = shift << 1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      serial_out <= IDLE_LVL;
      code_err   <= 1'b0;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      bit_cnt    <= bit_cnt_next;
      serial_out <= serial_next;
      if (load)
        code_err <= !legal;
    end
  end

endmodule

// File: tb/tb_therm_serial_encoder.sv
// Randomised self-checking bench: a frame-position model predicts the line and status outputs,
// and a behavioural receiver decodes serial_out back to a thermometer word.
module tb_therm_serial_encoder;

  localparam int D_W   = 8;
  localparam int BIN_W = $clog2(D_W);
  localparam int FL    = BIN_W + 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [D_W-1:0] therm_in = '0;
  logic           valid_in = 1'b0;
  logic           ready_out, serial_out, busy, frame_done, code_err;

  therm_serial_encoder #(.D_W(D_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .therm_in  (therm_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .serial_out(serial_out),
    .busy      (busy),
    .frame_done(frame_done),
    .code_err  (code_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: pos 0 is idle, 1..FL is the position within the current frame.
  int pos = 0;
  bit frame_bits[FL];
  bit m_err = 1'b0;

  // Receiver model state and expected decoded words.
  int rx_pos = 0;
  int rx_val = 0;
  int exp_q[$];

  function automatic bit m_ready();
    return (pos == 0) || (pos == FL);
  endfunction

  function automatic int sat_pop(input logic [D_W-1:0] t);
    int c;
    c = $countones(t);
    return (c > D_W - 1) ? D_W - 1 : c;
  endfunction

  function automatic bit is_legal(input logic [D_W-1:0] t);
    for (int k = 0; k < D_W; k++)
      if (int'(t) == (1 << k) - 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cycle();
    bit             xfer;
    bit             rst_s;
    logic [D_W-1:0] t;
    int             v;
    xfer  = valid_in && m_ready();
    rst_s = rst_n;
    t     = therm_in;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      pos   = 0;
      m_err = 1'b0;
    end else if (xfer) begin
      v = sat_pop(t);
      frame_bits[0] = 1'b1;
      for (int b = 0; b < BIN_W; b++) frame_bits[1 + b] = v[BIN_W - 1 - b];
      frame_bits[FL - 1] = 1'b0;
      pos   = 1;
      m_err = !is_legal(t);
      exp_q.push_back((1 << v) - 1);
    end else if (pos != 0) begin
      pos = (pos == FL) ? 0 : pos + 1;
    end

    check("serial_out", int'(serial_out), (pos == 0) ? 0 : int'(frame_bits[pos - 1]));
    check("busy", int'(busy), int'(pos != 0));
    check("ready_out", int'(ready_out), int'(m_ready()));
    check("frame_done", int'(frame_done), int'(pos == FL));
    check("code_err", int'(code_err), int'(m_err));

    if (!rst_s) begin
      rx_pos = 0;
      exp_q.delete();
    end else if (rx_pos == 0) begin
      if (serial_out) rx_pos = 1;
    end else if (rx_pos <= BIN_W) begin
      rx_val = ((rx_val << 1) | int'(serial_out)) & ((1 << BIN_W) - 1);
      rx_pos++;
    end else begin
      check("rx_stop", int'(serial_out), 0);
      if (exp_q.size() == 0) check("rx_unexpected_frame", 1, 0);
      else check("loopback", (1 << rx_val) - 1, exp_q.pop_front());
      rx_pos = 0;
    end
  endtask

  task automatic send(input logic [D_W-1:0] word);
    bit done;
    done     = 1'b0;
    valid_in = 1'b1;
    therm_in = word;
    for (int i = 0; i < 2 * FL + 2 && !done; i++) begin
      done = m_ready() && rst_n;
      cycle();
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    idle(3);

    send(8'b0000_0111);
    idle(FL + 1);

    send(8'h00);
    send(8'h7F);
    idle(FL + 1);

    send(8'b0000_1011);
    idle(FL);
    send(8'b0000_0001);
    idle(FL);
    send(8'hFF);
    idle(FL + 1);

    send(8'b0011_1111);
    valid_in = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    idle(2);
    send(8'b0001_1111);
    idle(FL + 1);

    for (int k = 0; k < D_W; k++) begin
      logic [D_W-1:0] w;
      w = D_W'((1 << k) - 1);
      send(w);
    end
    idle(FL + 1);

    for (int i = 0; i < 600; i++) begin
      logic [D_W-1:0] w;
      if ($urandom_range(0, 1) == 0) w = D_W'((1 << $urandom_range(0, D_W - 1)) - 1);
      else w = D_W'($urandom);
      therm_in = w;
      valid_in = ($urandom_range(0, 2) != 0);
      rst_n    = ($urandom_range(0, 150) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle(FL + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
